demux_burst_wr: RTL and testbench
=================================

DEMUX_BURST_WR -- requirements
Module: demux_burst_wr

Interface
REQ-001 SHALL have parameter AW, default 3, meaning address width.
REQ-002 SHALL have parameter DW, default 8, meaning data width.
REQ-003 SHALL derive N = 2**AW, the number of output enables (memory words).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-008 SHALL have port in_addr  input  AW  target/start address, plain binary, bit 0 = LSB.
REQ-009 SHALL have port in_data  input  DW  data to route.
REQ-010 SHALL have port in_mode  input  2  00 single, 01 broadcast, 10 burst, 11 no-op.
REQ-011 SHALL have port in_len  input  AW  burst beat count minus one (burst mode only).
REQ-012 SHALL have port outp  output  N  registered word enables.
REQ-013 SHALL have port out_data  output  DW  registered data accompanying outp.
REQ-014 SHALL have port out_valid  output  1  outp/out_data carry a beat this cycle.

Function
REQ-015 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1, and only then.
REQ-016 SHALL implement states IDLE and BURST; in_ready = 1 exactly when state=IDLE and rst=0.
REQ-017 SHALL present the first beat of an accepted request in the cycle after acceptance (latency 1), with all outputs driven from registers.
REQ-018 Single mode SHALL produce one beat: outp one-hot at bit in_addr, out_data=in_data; state stays IDLE.
REQ-019 Broadcast mode SHALL produce one beat: outp all ones, out_data=in_data; state stays IDLE.
REQ-020 No-op mode SHALL be accepted but produce no beat (out_valid=0 next cycle); state stays IDLE.
REQ-021 Burst mode SHALL produce in_len+1 consecutive beats, one per cycle, all with out_data=in_data captured at acceptance, at addresses in_addr, in_addr+1, ... modulo N (wrap N-1 -> 0).
REQ-022 Burst with in_len=0 SHALL behave exactly like single mode.
REQ-023 Burst with in_len>0 SHALL enter BURST with remaining-count rem=in_len; each BURST edge advances address by 1 mod N, decrements rem, and returns to IDLE on the edge where rem goes 1 -> 0.
REQ-024 in_ready SHALL therefore be 1 during the cycle showing the last burst beat, permitting back-to-back acceptance with no idle cycle between last beat and next first beat.
REQ-025 Single/broadcast/no-op requests SHALL sustain one acceptance per cycle.
REQ-026 in_addr, in_data, in_mode and in_len SHALL be ignored in any cycle without acceptance, including during BURST.
REQ-027 When out_valid=0, outp and out_data SHALL be all zeros.
REQ-028 When out_valid=1, outp SHALL have exactly one bit set, or all bits set in broadcast mode.
REQ-029 Burst with in_len=N-1 SHALL visit every address exactly once, ending at in_addr-1 mod N.

Reset
REQ-030 While rst=1: state=IDLE, rem=0, outp=0, out_data=0, out_valid=0, in_ready=0, asynchronously and independent of clk.
REQ-031 Assertion mid-burst SHALL abort the burst immediately; no remaining beats SHALL appear after rst deasserts.
REQ-032 The first acceptance after deassertion SHALL be possible on the first rising edge with rst=0.

Verification
REQ-033 AW=3: single, addr=5, data=0xA5 -> next cycle outp=0x20, out_data=0xA5, out_valid=1; following cycle out_valid=0, outp=0x00.
REQ-034 Broadcast, data=0x3C, then single addr=0 data=0x11 on next edge -> outp=0xFF/0x3C, then 0x01/0x11 on consecutive cycles.
REQ-035 Burst addr=6, len=3, data=0x77 -> outp 0x40, 0x80, 0x01, 0x02 on four consecutive cycles; in_ready=0 for the first three beats, 1 on the fourth.
REQ-036 Burst addr=2 len=1 followed by single addr=7 held valid -> beats 0x04, 0x08, then 0x80 with no gap; in_data changes during BURST ignored.
REQ-037 Burst addr=0 len=7, rst pulsed mid-cycle during beat 3 -> outputs zero immediately, no further beats; a single request after release is served normally.
REQ-038 No-op request and in_valid with in_ready=0 -> no beat produced, state unchanged.

Source files
------------

// File: rtl/demux_burst_wr.sv
// demux_burst_wr: routes a data word to one, all, or a wrapping run of
// consecutive word enables of a 2**AW-word memory, one beat per cycle.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   in_valid         request present
//   in_ready         request can be accepted this cycle (IDLE and not in reset)
//   in_addr          target / burst start address
//   in_data          data to route
//   in_mode          00 single, 01 broadcast, 10 burst, 11 no-op
//   in_len           burst beat count minus one
//   outp             registered word enables (one-hot, or all ones for broadcast)
//   out_data         registered data accompanying outp
//   out_valid        outp/out_data carry a beat this cycle
module demux_burst_wr #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AW-1:0]       in_addr,
  input  logic [DW-1:0]       in_data,
  input  logic [1:0]          in_mode,
  input  logic [AW-1:0]       in_len,
  output logic [(2**AW)-1:0]  outp,
  output logic [DW-1:0]       out_data,
  output logic                out_valid
);

  localparam int unsigned N = 2**AW;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BCAST  = 2'b01;
  localparam logic [1:0] MODE_BURST  = 2'b10;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t         state, state_n;
  logic [AW-1:0]  rem, rem_n;       // burst beats still to present after the current one
  logic [AW-1:0]  addr, addr_n;     // address of the beat currently presented
  logic [DW-1:0]  data, data_n;     // data captured at burst acceptance
  logic [N-1:0]   outp_n;
  logic [DW-1:0]  out_data_n;
  logic           out_valid_n;
  logic           accept;
  logic [AW-1:0]  addr_inc;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign addr_inc = addr + AW'(1);

  // State, burst bookkeeping and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      addr      <= '0;
      data      <= '0;
      outp      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      addr      <= addr_n;
      data      <= data_n;
      outp      <= outp_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
    end
  end

  // Next-state and next-beat logic; an idle cycle presents all zeros
  always_comb begin
    state_n     = state;
    rem_n       = rem;
    addr_n      = addr;
    data_n      = data;
    outp_n      = '0;
    out_data_n  = '0;
    out_valid_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (in_mode)
            MODE_SINGLE: begin
              outp_n      = N'(1) << in_addr;
              out_data_n  = in_data;
              out_valid_n = 1'b1;
            end
            MODE_BCAST: begin
              outp_n      = '1;
              out_data_n  = in_data;
              out_valid_n = 1'b1;
            end
            MODE_BURST: begin
              // First beat goes out now; a one-beat burst never leaves IDLE
              outp_n      = N'(1) << in_addr;
              out_data_n  = in_data;
              out_valid_n = 1'b1;
              if (in_len != '0) begin
                state_n = BURST;
                rem_n   = in_len;
                addr_n  = in_addr;
                data_n  = in_data;
              end
            end
            default: ;  // no-op: accepted, no beat
          endcase
        end
      end
      BURST: begin
        // Advance with natural AW-bit wrap; leave on the final beat so the
        // next request can be accepted while it is shown
        addr_n      = addr_inc;
        rem_n       = rem - AW'(1);
        outp_n      = N'(1) << addr_inc;
        out_data_n  = data;
        out_valid_n = 1'b1;
        if (rem == AW'(1)) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_demux_burst_wr.sv
// Testbench for demux_burst_wr: directed vectors plus random traffic checked
// against a queue of expected beats built from each accepted request.
module tb_demux_burst_wr;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned N  = 2**AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic [1:0]    in_mode;
  logic [AW-1:0] in_len;
  logic [N-1:0]  outp;
  logic [DW-1:0] out_data;
  logic          out_valid;

  demux_burst_wr #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_mode(in_mode), .in_len(in_len),
    .outp(outp), .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  o;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         pend[$];   // beats still to be presented, in order
  int            checks = 0;
  int            errors = 0;
  logic [N-1:0]  exp_outp;
  logic [DW-1:0] exp_data;
  logic          exp_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expand one accepted request into its beats
  task automatic push_beats(input logic [1:0] m, input logic [AW-1:0] a,
                            input logic [AW-1:0] l, input logic [DW-1:0] d);
    beat_t b;
    case (m)
      2'b00: begin b.o = N'(1) << a; b.d = d; pend.push_back(b); end
      2'b01: begin b.o = '1; b.d = d; pend.push_back(b); end
      2'b10: begin
        for (int k = 0; k <= int'(l); k++) begin
          b.o = N'(1) << ((int'(a) + k) % N);
          b.d = d;
          pend.push_back(b);
        end
      end
      default: ;
    endcase
  endtask

  // One clock: drive, check ready, clock, check the presented beat
  task automatic step(input logic v, input logic [1:0] m, input logic [AW-1:0] a,
                      input logic [AW-1:0] l, input logic [DW-1:0] d);
    logic acc;
    beat_t b;
    in_valid = v; in_mode = m; in_addr = a; in_len = l; in_data = d;
    #1;
    chk("in_ready", 32'(in_ready), (pend.size() == 0) ? 32'd1 : 32'd0);
    acc = v && (pend.size() == 0);
    @(posedge clk);
    if (acc) push_beats(m, a, l, d);
    if (pend.size() > 0) begin
      b = pend.pop_front();
      exp_valid = 1'b1; exp_outp = b.o; exp_data = b.d;
    end else begin
      exp_valid = 1'b0; exp_outp = '0; exp_data = '0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("outp", 32'(outp), 32'(exp_outp));
    chk("out_data", 32'(out_data), 32'(exp_data));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_outp"}, 32'(outp), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 2'b11; in_addr = '0; in_len = '0; in_data = '0;
    #3;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single addr 5 data A5, then an idle cycle
    step(1'b1, 2'b00, 3'd5, 3'd0, 8'hA5);
    chk("v033_outp", 32'(outp), 32'h20);
    step(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
    chk("v033_idle", 32'(outp), 32'h00);

    // Broadcast then single, back to back
    step(1'b1, 2'b01, 3'd3, 3'd0, 8'h3C);
    chk("v034_bcast", 32'(outp), 32'hFF);
    step(1'b1, 2'b00, 3'd0, 3'd0, 8'h11);
    chk("v034_single", 32'(outp), 32'h01);

    // Wrapping burst addr 6 len 3
    step(1'b1, 2'b10, 3'd6, 3'd3, 8'h77);
    chk("v035_b0", 32'(outp), 32'h40);
    step(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
    chk("v035_b1", 32'(outp), 32'h80);
    step(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
    chk("v035_b2", 32'(outp), 32'h01);
    step(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
    chk("v035_b3", 32'(outp), 32'h02);
    chk("v035_ready_last", 32'(in_ready), 32'd1);

    // Burst addr 2 len 1, single addr 7 held valid with changing data
    step(1'b1, 2'b10, 3'd2, 3'd1, 8'h55);
    chk("v036_b0", 32'(outp), 32'h04);
    step(1'b1, 2'b00, 3'd7, 3'd5, 8'h99);
    chk("v036_b1", 32'(outp), 32'h08);
    chk("v036_b1_data", 32'(out_data), 32'h55);
    step(1'b1, 2'b00, 3'd7, 3'd0, 8'hAB);
    chk("v036_next", 32'(outp), 32'h80);

    // Burst len 0 behaves as single; no-op yields no beat
    step(1'b1, 2'b10, 3'd4, 3'd0, 8'hC3);
    chk("len0_outp", 32'(outp), 32'h10);
    step(1'b1, 2'b11, 3'd1, 3'd2, 8'hEE);
    chk("noop_valid", 32'(out_valid), 32'd0);

    // Full-length burst from 0, reset pulsed during beat 3
    step(1'b1, 2'b10, 3'd0, 3'd7, 8'h5A);
    step(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
    step(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
    chk("v037_b2", 32'(outp), 32'h04);
    #2 rst = 1'b1;
    #1 chk_zero("midrst");
    pend.delete();
    @(posedge clk); #1;
    chk_zero("midrst_hold");
    #2 rst = 1'b0;
    step(1'b1, 2'b00, 3'd3, 3'd0, 8'h42);
    chk("v037_after", 32'(outp), 32'h08);
    step(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);

    // Full wrap from a non-zero start
    step(1'b1, 2'b10, 3'd5, 3'd7, 8'h81);
    for (int i = 0; i < 7; i++) step(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
    chk("wrap_last", 32'(outp), 32'h10);

    // Random traffic; inputs change freely during bursts
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), AW'($urandom),
           ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 2)),
           DW'($urandom));
    end
    for (int i = 0; i < N + 1; i++) step(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
